// File: rtl/arty_rst_ctrl.sv
// arty_rst_ctrl
// Reset sequencer between the Arty board clock/reset sources and the
// flexsoc_cm3 core. Conditions the board reset and both PLL lock inputs,
// then releases PORESETn and SYSRESETn in order, each after a stretch.
// Also runs core-requested warm resets and records the last reset cause.
//
// Build option: define ARTY_RST_LOCKUP_RESET_EN to make LOCKUP trigger a
// warm reset (cause 3). Left undefined, LOCKUP is ignored.
//
// Power-up: every register in this block comes up at zero after FPGA
// configuration. The HOLD state is encoded as zero and the busy flag is
// stored inverted (run_q), so the power-up state equals the RESET state,
// except RST_CAUSE, which comes up as 0 (PLL/power).

module arty_rst_ctrl #(
    parameter int POR_CYCLES = 16,
    parameter int SYS_CYCLES = 4
) (
    input  logic       hclk,
    input  logic       RESET,
    input  logic       HPLL_LOCKED,
    input  logic       TPLL_LOCKED,
    input  logic       SYSRESETREQ,
    input  logic       LOCKUP,
    output logic       PORESETn,
    output logic       SYSRESETn,
    output logic [1:0] RST_CAUSE,
    output logic       RST_BUSY
);

    // ------------------------------------------------------------------
    // Counter sizing: one counter serves both stretch phases and the
    // warm-reset minimum pulse, so it covers the larger of the two.
    // ------------------------------------------------------------------
    localparam int MAX_CYCLES = (POR_CYCLES > SYS_CYCLES) ? POR_CYCLES : SYS_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] SYS_LAST = CW'(SYS_CYCLES - 1);

    // Reset cause encodings as seen by software.
    localparam logic [1:0] CAUSE_PLL    = 2'd0;
    localparam logic [1:0] CAUSE_RESET  = 2'd1;
    localparam logic [1:0] CAUSE_SYSREQ = 2'd2;
    localparam logic [1:0] CAUSE_LOCKUP = 2'd3;

    // HOLD must stay the all-zero encoding so power-up lands in HOLD.
    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_POR_WAIT = 3'd1,
        ST_SYS_WAIT = 3'd2,
        ST_RUN      = 3'd3,
        ST_WARM     = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          poresetn_q;
    logic          sysresetn_q;
    logic          run_q;
    logic [1:0]    cause_q;

    // ------------------------------------------------------------------
    // PLL lock synchronisers: one two-flop chain per lock input. RESET
    // empties them so a release always waits for two fresh lock samples.
    // ------------------------------------------------------------------
    logic [1:0] lock_raw;
    logic [1:0] lock_sync;
    logic       lock_s;

    assign lock_raw = {TPLL_LOCKED, HPLL_LOCKED};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lock_sync
            logic meta_q;
            logic sync_q;

            // Two-stage capture of the asynchronous lock level into hclk.
            always_ff @(posedge hclk) begin
                if (RESET) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta_q <= lock_raw[gi];
                    sync_q <= meta_q;
                end
            end

            assign lock_sync[gi] = sync_q;
        end
    endgenerate

    // Both clocks must be locked before the core may leave reset.
    assign lock_s = &lock_sync;

    // ------------------------------------------------------------------
    // Warm-reset sources. LOCKUP only participates when the option is
    // compiled in; otherwise it is tied off and never reaches the FSM.
    // ------------------------------------------------------------------
    logic lockup_req;

`ifdef ARTY_RST_LOCKUP_RESET_EN
    assign lockup_req = LOCKUP;
`else
    logic unused_lockup;
    assign lockup_req    = 1'b0;
    assign unused_lockup = LOCKUP;
`endif

    // Incremented count, shared by the stretch and warm phases.
    assign cnt_d = cnt_q + CNT_ONE;

    // ------------------------------------------------------------------
    // Sequencer: state, counter and all outputs move together on one
    // edge, so the outputs are plain flops with no input-to-output path.
    // Priority: RESET, then lock loss, then LOCKUP, then SYSRESETREQ.
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (RESET) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            poresetn_q  <= 1'b0;
            sysresetn_q <= 1'b0;
            run_q       <= 1'b0;
            cause_q     <= CAUSE_RESET;
        end else if (!lock_s && (state_q != ST_HOLD)) begin
            // Either PLL dropped out: restart the full cold sequence.
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            poresetn_q  <= 1'b0;
            sysresetn_q <= 1'b0;
            run_q       <= 1'b0;
            cause_q     <= CAUSE_PLL;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    poresetn_q  <= 1'b0;
                    sysresetn_q <= 1'b0;
                    run_q       <= 1'b0;
                    if (lock_s) begin
                        state_q <= ST_POR_WAIT;
                        cnt_q   <= '0;
                    end
                end

                ST_POR_WAIT: begin
                    if (cnt_q == POR_LAST) begin
                        state_q    <= ST_SYS_WAIT;
                        cnt_q      <= '0;
                        poresetn_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_SYS_WAIT: begin
                    if (cnt_q == SYS_LAST) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= '0;
                        sysresetn_q <= 1'b1;
                        run_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_RUN: begin
                    if (lockup_req) begin
                        state_q     <= ST_WARM;
                        cnt_q       <= '0;
                        sysresetn_q <= 1'b0;
                        run_q       <= 1'b0;
                        cause_q     <= CAUSE_LOCKUP;
                    end else if (SYSRESETREQ) begin
                        state_q     <= ST_WARM;
                        cnt_q       <= '0;
                        sysresetn_q <= 1'b0;
                        run_q       <= 1'b0;
                        cause_q     <= CAUSE_SYSREQ;
                    end
                end

                ST_WARM: begin
                    // The counter parks at its last value so a long request
                    // only extends the pulse; release waits for the request
                    // (and lockup, if enabled) to drop.
                    if (cnt_q == SYS_LAST) begin
                        if (!SYSRESETREQ && !lockup_req) begin
                            state_q     <= ST_RUN;
                            cnt_q       <= '0;
                            sysresetn_q <= 1'b1;
                            run_q       <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q     <= ST_HOLD;
                    cnt_q       <= '0;
                    poresetn_q  <= 1'b0;
                    sysresetn_q <= 1'b0;
                    run_q       <= 1'b0;
                end
            endcase
        end
    end

    assign PORESETn  = poresetn_q;
    assign SYSRESETn = sysresetn_q;
    assign RST_CAUSE = cause_q;
    assign RST_BUSY  = ~run_q;

endmodule

// File: tb/tb_arty_rst_ctrl.sv
// Bench for arty_rst_ctrl: a timestamp model derives the expected outputs
// from edge numbers, and directed scenarios pin key edges to literals.

module tb_arty_rst_ctrl;

    localparam int POR = 16;
    localparam int SYS = 4;
`ifdef ARTY_RST_LOCKUP_RESET_EN
    localparam bit LK_EN = 1'b1;
`else
    localparam bit LK_EN = 1'b0;
`endif

    logic       hclk;
    logic       RESET;
    logic       HPLL_LOCKED;
    logic       TPLL_LOCKED;
    logic       SYSRESETREQ;
    logic       LOCKUP;
    logic       PORESETn;
    logic       SYSRESETn;
    logic [1:0] RST_CAUSE;
    logic       RST_BUSY;

    arty_rst_ctrl #(
        .POR_CYCLES(POR),
        .SYS_CYCLES(SYS)
    ) dut (
        .hclk        (hclk),
        .RESET       (RESET),
        .HPLL_LOCKED (HPLL_LOCKED),
        .TPLL_LOCKED (TPLL_LOCKED),
        .SYSRESETREQ (SYSRESETREQ),
        .LOCKUP      (LOCKUP),
        .PORESETn    (PORESETn),
        .SYSRESETn   (SYSRESETn),
        .RST_CAUSE   (RST_CAUSE),
        .RST_BUSY    (RST_BUSY)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // ------------------------------------------------------------------
    // Model: input history per edge plus timestamps.
    //   m_g   edge on which the cold sequence left HOLD
    //   m_wf  edge on which the current warm reset began
    // Outputs follow from arithmetic on those timestamps.
    // ------------------------------------------------------------------
    bit   rst_h [0:8191];
    bit   lk_h  [0:8191];
    bit   m_down  = 1'b1;
    bit   m_warm  = 1'b0;
    int   m_g     = 0;
    int   m_wf    = 0;
    int   m_cause = 0;
    logic exp_por, exp_sys, exp_busy;

    always @(posedge hclk) begin
        int  n;
        bit  ls;
        bit  in_run;
        edge_n = edge_n + 1;
        n = edge_n;
        rst_h[n] = RESET;
        lk_h[n]  = HPLL_LOCKED && TPLL_LOCKED;
        // lock seen by the sequencer = lock sampled two edges ago, unless
        // a reset intervened on either of those edges
        ls = (n >= 3) && lk_h[n-2] && !rst_h[n-2] && !rst_h[n-1];
        in_run = !m_down && !m_warm && (n > m_g + POR + SYS);
        if (RESET) begin
            m_down = 1'b1; m_warm = 1'b0; m_cause = 1;
        end else if (!ls && !m_down) begin
            m_down = 1'b1; m_warm = 1'b0; m_cause = 0;
        end else if (m_down) begin
            if (ls) begin m_down = 1'b0; m_g = n; end
        end else if (in_run) begin
            if (LK_EN && LOCKUP) begin
                m_warm = 1'b1; m_wf = n; m_cause = 3;
            end else if (SYSRESETREQ) begin
                m_warm = 1'b1; m_wf = n; m_cause = 2;
            end
        end else if (m_warm && (n >= m_wf + SYS) && !SYSRESETREQ && !(LK_EN && LOCKUP)) begin
            m_warm = 1'b0;
        end
        exp_por  = !m_down && (n >= m_g + POR);
        exp_sys  = !m_down && !m_warm && (n >= m_g + POR + SYS);
        exp_busy = !exp_sys;
    end

    // Per-cycle compare of every output against the model.
    always @(negedge hclk) begin
        if (edge_n >= 1) begin
            n_cmp++;
            if ({PORESETn, SYSRESETn, RST_BUSY, RST_CAUSE} !==
                {exp_por, exp_sys, exp_busy, 2'(m_cause)}) begin
                n_bad++;
                if (n_bad <= 30)
                    $display("FAIL model edge %0d: got por=%b sys=%b busy=%b cause=%0d, want por=%b sys=%b busy=%b cause=%0d",
                             edge_n, PORESETn, SYSRESETn, RST_BUSY, RST_CAUSE,
                             exp_por, exp_sys, exp_busy, m_cause);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic tick(input int k);
        for (int i = 0; i < k; i++) @(negedge hclk);
    endtask

    task automatic check(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return PORESETn;
            1:       return SYSRESETn;
            default: return RST_BUSY;
        endcase
    endfunction

    // Returns the edge after which signal sel first reads val, or -1.
    task automatic wait_for(input int sel, input logic val, output int e);
        e = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge hclk);
            if (sig(sel) === val) begin
                e = edge_n;
                break;
            end
        end
        if (e < 0) $display("timeout waiting for signal %0d = %b", sel, val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int rel, w, e, f, r, c;
        RESET = 1'b1; HPLL_LOCKED = 1'b1; TPLL_LOCKED = 1'b1;
        SYSRESETREQ = 1'b0; LOCKUP = 1'b0;

        // reset state
        tick(3);
        check("reset_por", int'(PORESETn), 0);
        check("reset_sys", int'(SYSRESETn), 0);
        check("reset_busy", int'(RST_BUSY), 1);
        check("reset_cause", int'(RST_CAUSE), 1);

        // cold start: rel is edge 1 of the sequence
        RESET = 1'b0; rel = edge_n + 1;
        wait_for(0, 1'b1, e); check("cold_por_edge", e - rel + 1, 19);
        wait_for(1, 1'b1, e); check("cold_sys_edge", e - rel + 1, 23);
        check("cold_busy", int'(RST_BUSY), 0);
        check("cold_cause", int'(RST_CAUSE), 1);
        tick(5);

        // warm reset, one-cycle request
        SYSRESETREQ = 1'b1; w = edge_n + 1;
        tick(1); SYSRESETREQ = 1'b0;
        check("warm_sys_fall", int'(SYSRESETn), 0);
        check("warm_por_held", int'(PORESETn), 1);
        check("warm_cause", int'(RST_CAUSE), 2);
        wait_for(1, 1'b1, e); check("warm_rise_after_fall", e - w, SYS);
        tick(3);

        // warm reset, request held 20 cycles
        SYSRESETREQ = 1'b1; w = edge_n + 1;
        tick(20); SYSRESETREQ = 1'b0;
        check("held_sys_low", int'(SYSRESETn), 0);
        wait_for(1, 1'b1, e); check("held_rise_edge", e - w, 20);
        tick(3);

        // LOCKUP alone for three cycles
        LOCKUP = 1'b1; c = edge_n + 1;
        tick(3); LOCKUP = 1'b0;
        if (LK_EN) begin
            check("lockup_cause", int'(RST_CAUSE), 3);
            wait_for(1, 1'b1, e); check("lockup_rise", e - c, SYS);
        end else begin
            check("lockup_ignored_busy", int'(RST_BUSY), 0);
            check("lockup_ignored_cause", int'(RST_CAUSE), 2);
        end
        tick(3);

        // LOCKUP and SYSRESETREQ on the same edge
        LOCKUP = 1'b1; SYSRESETREQ = 1'b1; c = edge_n + 1;
        tick(1); LOCKUP = 1'b0; SYSRESETREQ = 1'b0;
        check("both_cause", int'(RST_CAUSE), LK_EN ? 3 : 2);
        wait_for(1, 1'b1, e); check("both_rise", e - c, SYS);
        tick(3);

        // lock loss: TPLL low for 5 cycles
        TPLL_LOCKED = 1'b0; f = edge_n + 1;
        tick(2); check("loss_por_still_high", int'(PORESETn), 1);
        tick(1);
        check("loss_por_low", int'(PORESETn), 0);
        check("loss_sys_low", int'(SYSRESETn), 0);
        check("loss_cause", int'(RST_CAUSE), 0);
        check("loss_latency", edge_n - f + 1, 3);
        tick(2);
        TPLL_LOCKED = 1'b1; r = edge_n + 1;
        wait_for(0, 1'b1, e); check("relock_por_edge", e - r + 1, 2 + 1 + POR);
        wait_for(1, 1'b1, e); check("relock_sys_edge", e - r + 1, 2 + 1 + POR + SYS);
        tick(3);

        // one-cycle HPLL glitch restarts the cold sequence
        HPLL_LOCKED = 1'b0;
        tick(1); HPLL_LOCKED = 1'b1; r = edge_n + 1;
        wait_for(0, 1'b0, e); check("glitch_por_low", e - r + 1, 2);
        wait_for(0, 1'b1, e); check("glitch_por_edge", e - r + 1, 19);
        wait_for(1, 1'b1, e); check("glitch_sys_edge", e - r + 1, 23);
        tick(3);

        // RESET asserted in SYS_WAIT with the counter at 2
        RESET = 1'b1; tick(1); RESET = 1'b0; rel = edge_n + 1;
        wait_for(0, 1'b1, e); check("rst2_por_edge", e - rel + 1, 19);
        tick(2);
        RESET = 1'b1; tick(1); RESET = 1'b0; rel = edge_n + 1;
        check("midrst_por", int'(PORESETn), 0);
        check("midrst_sys", int'(SYSRESETn), 0);
        check("midrst_busy", int'(RST_BUSY), 1);
        check("midrst_cause", int'(RST_CAUSE), 1);
        wait_for(0, 1'b1, e); check("rst3_por_edge", e - rel + 1, 19);
        wait_for(1, 1'b1, e); check("rst3_sys_edge", e - rel + 1, 23);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
